tournament_predictor: RTL and testbench
=======================================

Name: tournament_predictor

Overview:
- Fetch-stage conditional-branch direction predictor. It combines a local-history predictor, a gshare global predictor and a per-PC chooser.
- Feeds decode with the final, local and global predictions that the branch resolver checks.
- Consumes the resolver's three per-predictor correctness bits to train its tables and to repair the speculative global history one cycle later.

Parameters:
- PC_WIDTH, 32, PC width.
- LHT_IDX, 6, log2 of local-history-table entries; indexed by PC[LHT_IDX+1:2].
- LHIST_BITS, 8, local history length; the local PHT has 2^LHIST_BITS 2-bit counters.
- GHR_BITS, 8, global history length; the global PHT has 2^GHR_BITS counters.
- CHO_IDX, 8, log2 of chooser entries; indexed by PC[CHO_IDX+1:2].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- F_PC_i  in  PC_WIDTH  fetch PC.
- F_branch_i  in  1  fetched instruction is a conditional branch (predecode).
- F_stall_i  in  1  fetch held; no speculative history shift.
- F_predict_o  out  1  final prediction (1 = taken).
- F_local_predict_o  out  1  local predictor's direction.
- F_global_predict_o  out  1  global predictor's direction.
- F_ghr_o  out  GHR_BITS  GHR snapshot before this branch's shift; carried down the pipe.
- D_update_i  in  1  a conditional branch resolved this cycle.
- D_PC_i  in  PC_WIDTH  resolved branch PC.
- D_ghr_i  in  GHR_BITS  snapshot carried from fetch.
- D_predict_i, D_local_predict_i, D_global_predict_i  in  1 each  predictions carried from fetch.
- D_train_taken_i, D_train_local_taken_i, D_train_global_taken_i  in  1 each  1 = that prediction was correct.

Behaviour:
- Lookup (combinational from F_PC_i):
  - lh = LHT[PC idx].
  - local = LPHT[lh][1].
  - gidx = GHR ^ PC[GHR_BITS+1:2]; global = GPHT[gidx][1].
  - F_predict_o = CHO[idx][1] ? global : local.
  - F_ghr_o = GHR.
- Actual outcome at update: A = D_local_predict_i ^ ~D_train_local_taken_i.
- Training, on the rising edge when D_update_i = 1; all table writes are visible from the next cycle:
  - LPHT[LHT[D idx]] saturates toward A.
  - LHT[D idx] <= {LHT[D idx][LHIST_BITS-2:0], A}.
  - GPHT[D_ghr_i ^ D_PC_i bits] saturates toward A.
  - CHO[D idx] changes only if D_train_local_taken_i != D_train_global_taken_i: +1 (sat 3) if global correct, -1 (sat 0) if local correct.
- Counters: 2-bit saturating 0..3; MSB = taken/global.
- GHR update, in priority order:
  1. D_update_i & ~D_train_taken_i (mispredict): GHR <= {D_ghr_i[GHR_BITS-2:0], A}. Any same-cycle fetch shift is discarded, since fetch is being flushed.
  2. Else if F_branch_i & ~F_stall_i: GHR <= {GHR[GHR_BITS-2:0], F_predict_o}.
  3. Else GHR holds.
- Read/write collision: a lookup in the same cycle as an update to the same entry sees the pre-update value. No bypass.
- Reset (async, any time, including mid-update):
  - all LPHT/GPHT = 2'b01 (weakly not-taken).
  - all CHO = 2'b01 (weakly local).
  - LHT = 0, GHR = 0.
  - Consequently F_predict_o = F_local_predict_o = F_global_predict_o = 0 and F_ghr_o = 0.
  - An update coincident with reset deassertion is dropped.
- D_update_i = 0: no state change except fetch GHR shift. The D_* inputs are ignored.

Optional Feature:
- Macro: TP_PERF_CNT_EN.
- Defined:
  - adds outputs perf_branch_o[31:0] (count of D_update_i) and perf_mispred_o[31:0] (count of D_update_i & ~D_train_taken_i).
  - both reset to 0 on rst_i and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then F_PC_i=0x100, F_branch_i=1: all three predictions = 0, F_ghr_o = 0x00. One cycle later F_ghr_o = 0x00 (predicted 0 shifted in).
- Always-taken branch at 0x100, nine updates with D_local_predict_i=0, D_train_local_taken_i=0 (A=1). Expected state after update 8 and after update 9:
  - after update 8: LHT[0] = 0xFF, F_local_predict_o = 0.
  - after update 9: LPHT[0xFF] = 2'b10 and F_local_predict_o = 1.
- Mispredict: D_update_i=1, D_ghr_i=0x0F, D_train_taken_i=0, A=1, same cycle F_branch_i=1. Expected: next GHR = 0x1F; the fetch shift is ignored.
- Chooser: PC 0x200, local correct=0, global correct=1, four updates. Expected: CHO 01→10→11→11; F_predict_o follows F_global_predict_o from the first update onward.
- Both correct (1,1) or both wrong (0,0): chooser unchanged. Assert rst_i mid-sequence: tables back to 01, GHR = 0, outputs 0 combinationally.
- With TP_PERF_CNT_EN: 10 updates, 3 with D_train_taken_i=0. Expected: perf_branch_o = 10, perf_mispred_o = 3.

Source files
------------

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: local-history PHT, gshare global PHT and per-PC chooser,
// with speculative GHR repaired on mispredict. Optional TP_PERF_CNT_EN adds perf counters.
module tournament_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int LHT_IDX    = 6,
    parameter int LHIST_BITS = 8,
    parameter int GHR_BITS   = 8,
    parameter int CHO_IDX    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PC_WIDTH-1:0]   F_PC_i,
    input  logic                  F_branch_i,
    input  logic                  F_stall_i,
    output logic                  F_predict_o,
    output logic                  F_local_predict_o,
    output logic                  F_global_predict_o,
    output logic [GHR_BITS-1:0]   F_ghr_o,
    input  logic                  D_update_i,
    input  logic [PC_WIDTH-1:0]   D_PC_i,
    input  logic [GHR_BITS-1:0]   D_ghr_i,
    input  logic                  D_predict_i,
    input  logic                  D_local_predict_i,
    input  logic                  D_global_predict_i,
    input  logic                  D_train_taken_i,
    input  logic                  D_train_local_taken_i,
    input  logic                  D_train_global_taken_i
`ifdef TP_PERF_CNT_EN
    ,
    output logic [31:0]           perf_branch_o,
    output logic [31:0]           perf_mispred_o
`endif
);
    localparam int LHT_N  = 1 << LHT_IDX;
    localparam int LPHT_N = 1 << LHIST_BITS;
    localparam int GPHT_N = 1 << GHR_BITS;
    localparam int CHO_N  = 1 << CHO_IDX;

    logic [LHIST_BITS-1:0] lht_q  [LHT_N];
    logic [LHIST_BITS-1:0] lht_d  [LHT_N];
    logic [1:0]            lpht_q [LPHT_N];
    logic [1:0]            lpht_d [LPHT_N];
    logic [1:0]            gpht_q [GPHT_N];
    logic [1:0]            gpht_d [GPHT_N];
    logic [1:0]            cho_q  [CHO_N];
    logic [1:0]            cho_d  [CHO_N];
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'd3) ? c : c + 2'd1;
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    // Fetch-side lookup
    logic [LHT_IDX-1:0]    f_lidx;
    logic [CHO_IDX-1:0]    f_cidx;
    logic [GHR_BITS-1:0]   f_gidx;
    logic [LHIST_BITS-1:0] f_lh;

    assign f_lidx = F_PC_i[LHT_IDX+1:2];
    assign f_cidx = F_PC_i[CHO_IDX+1:2];
    assign f_gidx = ghr_q ^ F_PC_i[GHR_BITS+1:2];
    assign f_lh   = lht_q[f_lidx];

    assign F_local_predict_o  = lpht_q[f_lh][1];
    assign F_global_predict_o = gpht_q[f_gidx][1];
    assign F_predict_o        = cho_q[f_cidx][1] ? F_global_predict_o : F_local_predict_o;
    assign F_ghr_o            = ghr_q;

    // Resolve-side training; the true outcome is recovered from the local prediction
    logic                  actual;
    logic                  mispredict;
    logic [LHT_IDX-1:0]    d_lidx;
    logic [CHO_IDX-1:0]    d_cidx;
    logic [GHR_BITS-1:0]   d_gidx;
    logic [LHIST_BITS-1:0] d_lh;

    assign actual     = D_local_predict_i ^ ~D_train_local_taken_i;
    assign mispredict = D_update_i & ~D_train_taken_i;
    assign d_lidx     = D_PC_i[LHT_IDX+1:2];
    assign d_cidx     = D_PC_i[CHO_IDX+1:2];
    assign d_gidx     = D_ghr_i ^ D_PC_i[GHR_BITS+1:2];
    assign d_lh       = lht_q[d_lidx];

    always_comb begin
        lht_d  = lht_q;
        lpht_d = lpht_q;
        gpht_d = gpht_q;
        cho_d  = cho_q;
        if (D_update_i) begin
            lpht_d[d_lh]   = sat2(lpht_q[d_lh], actual);
            lht_d[d_lidx]  = {lht_q[d_lidx][LHIST_BITS-2:0], actual};
            gpht_d[d_gidx] = sat2(gpht_q[d_gidx], actual);
            if (D_train_local_taken_i != D_train_global_taken_i)
                cho_d[d_cidx] = sat2(cho_q[d_cidx], D_train_global_taken_i);
        end
    end

    // Mispredict repair overrides the speculative shift because fetch is being flushed
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict)
            ghr_d = {D_ghr_i[GHR_BITS-2:0], actual};
        else if (F_branch_i && !F_stall_i)
            ghr_d = {ghr_q[GHR_BITS-2:0], F_predict_o};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LHT_N; i++)  lht_q[i]  <= '0;
            for (int i = 0; i < LPHT_N; i++) lpht_q[i] <= 2'b01;
            for (int i = 0; i < GPHT_N; i++) gpht_q[i] <= 2'b01;
            for (int i = 0; i < CHO_N; i++)  cho_q[i]  <= 2'b01;
            ghr_q <= '0;
        end else begin
            lht_q  <= lht_d;
            lpht_q <= lpht_d;
            gpht_q <= gpht_d;
            cho_q  <= cho_d;
            ghr_q  <= ghr_d;
        end
    end

`ifdef TP_PERF_CNT_EN
    logic [31:0] perf_branch_q, perf_branch_d;
    logic [31:0] perf_mispred_q, perf_mispred_d;

    always_comb begin
        perf_branch_d  = perf_branch_q + {31'd0, D_update_i};
        perf_mispred_d = perf_mispred_q + {31'd0, mispredict};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_branch_q  <= '0;
            perf_mispred_q <= '0;
        end else begin
            perf_branch_q  <= perf_branch_d;
            perf_mispred_q <= perf_mispred_d;
        end
    end

    assign perf_branch_o  = perf_branch_q;
    assign perf_mispred_o = perf_mispred_q;
`endif

    // Final and global predictions are carried for the resolver only; upper PC bits are untagged
    logic unused_ok;
    assign unused_ok = ^{F_PC_i, D_PC_i, D_predict_i, D_global_predict_i};
endmodule

// File: tb/tb_tournament_predictor.sv
// Scoreboard bench for tournament_predictor: directed plus random stimulus, expectations
// from an integer-array reference model, checked by a negedge monitor.
module tb_tournament_predictor;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] F_PC_i = '0;
    logic        F_branch_i = 1'b0;
    logic        F_stall_i = 1'b0;
    logic        F_predict_o, F_local_predict_o, F_global_predict_o;
    logic [7:0]  F_ghr_o;
    logic        D_update_i = 1'b0;
    logic [31:0] D_PC_i = '0;
    logic [7:0]  D_ghr_i = '0;
    logic        D_predict_i = 1'b0;
    logic        D_local_predict_i = 1'b0;
    logic        D_global_predict_i = 1'b0;
    logic        D_train_taken_i = 1'b1;
    logic        D_train_local_taken_i = 1'b1;
    logic        D_train_global_taken_i = 1'b1;
`ifdef TP_PERF_CNT_EN
    logic [31:0] perf_branch_o, perf_mispred_o;
`endif

    tournament_predictor dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .F_PC_i(F_PC_i), .F_branch_i(F_branch_i), .F_stall_i(F_stall_i),
        .F_predict_o(F_predict_o), .F_local_predict_o(F_local_predict_o),
        .F_global_predict_o(F_global_predict_o), .F_ghr_o(F_ghr_o),
        .D_update_i(D_update_i), .D_PC_i(D_PC_i), .D_ghr_i(D_ghr_i),
        .D_predict_i(D_predict_i), .D_local_predict_i(D_local_predict_i),
        .D_global_predict_i(D_global_predict_i), .D_train_taken_i(D_train_taken_i),
        .D_train_local_taken_i(D_train_local_taken_i),
        .D_train_global_taken_i(D_train_global_taken_i)
`ifdef TP_PERF_CNT_EN
        , .perf_branch_o(perf_branch_o), .perf_mispred_o(perf_mispred_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass = 0;
    logic [10:0] expq[$];

    // Reference model: plain integer tables, counters kept in 0..3
    int m_lht[64];
    int m_lpht[256];
    int m_gpht[256];
    int m_cho[256];
    int m_ghr;
    int m_nbr, m_nmis;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_lht[i] = 0;
        for (int i = 0; i < 256; i++) begin
            m_lpht[i] = 1;
            m_gpht[i] = 1;
            m_cho[i]  = 1;
        end
        m_ghr = 0;
        m_nbr = 0;
        m_nmis = 0;
    endtask

    function automatic int bump(int c, bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    // Record expectation for this cycle, then advance model and clock
    task automatic tick();
        int  lh, gi, li, ci, dgi;
        bit  loc, glb, fin, a;
        if (rst_i) model_reset();
        lh  = m_lht[int'((F_PC_i >> 2) & 32'd63)];
        loc = m_lpht[lh] >= 2;
        gi  = (m_ghr ^ int'(F_PC_i >> 2)) & 255;
        glb = m_gpht[gi] >= 2;
        fin = (m_cho[int'((F_PC_i >> 2) & 32'd255)] >= 2) ? glb : loc;
        if (F_branch_i) expq.push_back({fin, loc, glb, 8'(m_ghr)});
        if (!rst_i) begin
            a = D_local_predict_i ^ !D_train_local_taken_i;
            if (D_update_i && !D_train_taken_i)
                m_ghr = ((int'(D_ghr_i) * 2) + a) & 255;
            else if (F_branch_i && !F_stall_i)
                m_ghr = ((m_ghr * 2) + fin) & 255;
            if (D_update_i) begin
                li  = int'((D_PC_i >> 2) & 32'd63);
                ci  = int'((D_PC_i >> 2) & 32'd255);
                dgi = int'((D_ghr_i ^ D_PC_i[9:2]));
                m_lpht[m_lht[li]] = bump(m_lpht[m_lht[li]], a);
                m_lht[li] = ((m_lht[li] * 2) + a) & 255;
                m_gpht[dgi] = bump(m_gpht[dgi], a);
                if (D_train_local_taken_i != D_train_global_taken_i)
                    m_cho[ci] = bump(m_cho[ci], D_train_global_taken_i);
                m_nbr++;
                if (!D_train_taken_i) m_nmis++;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        F_branch_i = 0; F_stall_i = 0; D_update_i = 0;
        D_train_taken_i = 1; D_train_local_taken_i = 1; D_train_global_taken_i = 1;
        D_local_predict_i = 0; D_global_predict_i = 0; D_predict_i = 0;
        D_ghr_i = '0; D_PC_i = '0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [7:0] g, input bit lp,
                           input bit tt, input bit tl, input bit tg);
        D_update_i = 1; D_PC_i = pc; D_ghr_i = g; D_local_predict_i = lp;
        D_train_taken_i = tt; D_train_local_taken_i = tl; D_train_global_taken_i = tg;
    endtask

    always @(negedge clk_i) begin
        logic [10:0] got, exp_v;
        if (F_branch_i === 1'b1) begin
            got = {F_predict_o, F_local_predict_o, F_global_predict_o, F_ghr_o};
            n_checks++;
            if (expq.size() == 0) begin
                $display("FAIL scoreboard_empty t=%0t got=%h required an expectation", $time, got);
            end else begin
                exp_v = expq.pop_front();
                if (got === exp_v) n_pass++;
                else $display("FAIL pred t=%0t pred/loc/glb/ghr got=%b/%b/%b/%h required=%b/%b/%b/%h",
                              $time, got[10], got[9], got[8], got[7:0],
                              exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;

        // Fresh state at 0x100, then GHR after shifting in a not-taken prediction
        F_PC_i = 32'h100; F_branch_i = 1;
        tick();
        tick();

        // Always-taken branch trained nine times
        for (int i = 0; i < 9; i++) begin
            resolve(32'h100, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
            F_PC_i = 32'h100; F_branch_i = 1;
            tick();
        end
        idle(); F_PC_i = 32'h100; F_branch_i = 1;
        tick();

        // Mispredict repair beats same-cycle fetch shift
        resolve(32'h140, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        F_PC_i = 32'h180; F_branch_i = 1;
        tick();
        idle(); F_PC_i = 32'h180; F_branch_i = 1;
        tick();

        // Chooser moves toward global
        for (int i = 0; i < 4; i++) begin
            resolve(32'h200, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
            F_PC_i = 32'h200; F_branch_i = 1;
            tick();
        end
        // Agreeing correctness leaves the chooser alone
        resolve(32'h200, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        resolve(32'h200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle(); F_PC_i = 32'h200; F_branch_i = 1;
        tick();

        // Reset mid-sequence, with an update present that must be dropped
        resolve(32'h100, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
        F_PC_i = 32'h100; F_branch_i = 1; rst_i = 1;
        tick();
        rst_i = 0; idle(); F_PC_i = 32'h200; F_branch_i = 1;
        tick();

        // Random traffic over a small PC set so entries collide and saturate
        for (int i = 0; i < 600; i++) begin
            F_PC_i     = 32'h100 + ($urandom_range(0, 15) << 2);
            F_branch_i = ($urandom_range(0, 9) < 7);
            F_stall_i  = ($urandom_range(0, 9) < 2);
            D_update_i = $urandom_range(0, 1);
            D_PC_i     = 32'h100 + ($urandom_range(0, 15) << 2);
            D_ghr_i    = 8'($urandom);
            D_predict_i            = $urandom_range(0, 1);
            D_local_predict_i      = $urandom_range(0, 1);
            D_global_predict_i     = $urandom_range(0, 1);
            D_train_taken_i        = ($urandom_range(0, 3) != 0);
            D_train_local_taken_i  = $urandom_range(0, 1);
            D_train_global_taken_i = $urandom_range(0, 1);
            tick();
        end

        idle();
        tick();
        n_checks++;
        if (expq.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain leftover=%0d required=0", expq.size());
`ifdef TP_PERF_CNT_EN
        n_checks++;
        if (perf_branch_o == 32'(m_nbr)) n_pass++;
        else $display("FAIL perf_branch got=%0d required=%0d", perf_branch_o, m_nbr);
        n_checks++;
        if (perf_mispred_o == 32'(m_nmis)) n_pass++;
        else $display("FAIL perf_mispred got=%0d required=%0d", perf_mispred_o, m_nmis);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
